// File: rtl/freq_div_prog.sv
// Runtime-programmable multi-channel clock divider: any integer divisor 2..2^W-1 at 50% duty,
// glitch-free reloads at period boundaries, per-channel period tick and a global phase-align pulse.
module freq_div_prog #(
  parameter int NCH     = 3,
  parameter int W       = 4,
  parameter int DEF_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   load,
  input  logic [NCH*W-1:0] div_val,
  input  logic             sync,
  output logic [NCH-1:0]   div_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [W-1:0] DEF_D = W'(DEF_DIV);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t       state, state_nx;
    logic [W-1:0] cnt, cnt_nx;
    logic [W-1:0] d_act, d_nx;
    logic [W-1:0] shadow, shadow_nx;
    logic [W-1:0] v;
    logic         pending, pending_nx;
    logic         out_p, out_p_nx;
    logic         out_n;
    logic         err;
    logic         ld_ok, ld_bad, wrap;

    assign v      = div_val[i*W +: W];
    assign ld_ok  = load[i] && (v > W'(1));
    assign ld_bad = load[i] && (v < W'(2));
    assign wrap   = (state != IDLE) && (cnt == d_act - W'(1));

    always_comb begin
      // NOTE: every signal gets its hold value first so no path through this block infers a latch.
      state_nx   = state;
      cnt_nx     = cnt;
      d_nx       = d_act;
      shadow_nx  = shadow;
      pending_nx = pending;
      out_p_nx   = out_p;
      if (state == IDLE) begin
        if (ld_ok) d_nx = v;
        if (en[i]) begin
          state_nx = RUN;
          cnt_nx   = '0;
          out_p_nx = 1'b1;
        end
      end else begin
        state_nx = en[i] ? RUN : DRAIN;
        if (sync || wrap) begin
          // Period boundary (natural or forced): a load on this very edge wins over the shadow.
          cnt_nx     = '0;
          out_p_nx   = 1'b1;
          pending_nx = 1'b0;
          d_nx       = ld_ok ? v : (pending ? shadow : d_act);
          if (ld_ok) shadow_nx = v;
          if (!sync && !en[i]) begin
            state_nx = IDLE;
            out_p_nx = 1'b0;
          end
        end else begin
          cnt_nx   = cnt + W'(1);
          out_p_nx = cnt_nx < (d_act >> 1);
          if (ld_ok) begin
            shadow_nx  = v;
            pending_nx = 1'b1;
          end
        end
      end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state   <= IDLE;
        cnt     <= '0;
        d_act   <= DEF_D;
        shadow  <= '0;
        pending <= 1'b0;
        out_p   <= 1'b0;
        err     <= 1'b0;
      end else begin
        state   <= state_nx;
        cnt     <= cnt_nx;
        d_act   <= d_nx;
        shadow  <= shadow_nx;
        pending <= pending_nx;
        out_p   <= out_p_nx;
        if (ld_bad) err <= 1'b1;
      end
    end

    // Half-cycle extension for odd divisors; masked for even ones so div_out stays a pure OR.
    always_ff @(negedge clk or negedge rst) begin
      if (!rst) out_n <= 1'b0;
      else      out_n <= out_p & d_act[0];
    end

    assign div_out[i] = out_p | out_n;
    assign tick[i]    = wrap;
    assign busy[i]    = pending;
    assign cfg_err[i] = err;
  end

endmodule

// File: tb/tb_freq_div_prog.sv
// Self-checking bench for freq_div_prog: directed vector table, hand-written corner sequences,
// and randomized traffic against a half-cycle-resolution behavioural model.
module tb_freq_div_prog;
  localparam int NCH = 3;
  localparam int W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sync = 1'b0;
  logic [NCH-1:0]   en = '0, load = '0;
  logic [NCH*W-1:0] div_val = '0;
  logic [NCH-1:0]   div_out, tick, busy, cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  freq_div_prog #(.NCH(NCH), .W(W), .DEF_DIV(3)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .div_val(div_val), .sync(sync),
    .div_out(div_out), .tick(tick), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Model: a running channel at period position pos is high for the first D of its 2*D half-cycles.
  int m_act[NCH], m_pos[NCH], m_d[NCH], m_sh[NCH], m_pend[NCH], m_err[NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_act[c] = 0; m_pos[c] = 0; m_d[c] = 3; m_sh[c] = 0; m_pend[c] = 0; m_err[c] = 0;
    end
  endtask

  task automatic model_step();
    int v;
    bit ok;
    for (int c = 0; c < NCH; c++) begin
      v  = int'(div_val[c*W +: W]);
      ok = load[c] && v >= 2;
      if (load[c] && v < 2) m_err[c] = 1;
      if (m_act[c] == 0) begin
        if (ok) m_d[c] = v;
        if (en[c]) begin
          m_act[c] = 1;
          m_pos[c] = 0;
        end
      end else if (sync || m_pos[c] == m_d[c] - 1) begin
        m_d[c]    = ok ? v : (m_pend[c] != 0 ? m_sh[c] : m_d[c]);
        m_pend[c] = 0;
        m_pos[c]  = 0;
        if (!sync && !en[c]) m_act[c] = 0;
      end else begin
        m_pos[c]++;
        if (ok) begin
          m_sh[c]   = v;
          m_pend[c] = 1;
        end
      end
    end
  endtask

  function automatic logic [NCH-1:0] m_out(input int half);
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = (m_act[c] != 0) && (2 * m_pos[c] + half < m_d[c]);
    return r;
  endfunction

  function automatic logic [NCH-1:0] m_tick();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = (m_act[c] != 0) && (m_pos[c] == m_d[c] - 1);
    return r;
  endfunction

  function automatic logic [NCH-1:0] m_busy();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = m_pend[c] != 0;
    return r;
  endfunction

  function automatic logic [NCH-1:0] m_errv();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = m_err[c] != 0;
    return r;
  endfunction

  // Entered and left at negedge+2; outputs are sampled 2 time units after each clock edge.
  task automatic cycle(input logic [NCH-1:0] e, input logic [NCH-1:0] l,
                       input logic [NCH*W-1:0] dv, input logic s, input string tag,
                       output logic [NCH-1:0] hi, output logic [NCH-1:0] lo,
                       output logic [NCH-1:0] tk, output logic [NCH-1:0] bz,
                       output logic [NCH-1:0] er);
    en = e; load = l; div_val = dv; sync = s;
    @(posedge clk);
    model_step();
    #2;
    hi = div_out; tk = tick; bz = busy; er = cfg_err;
    check({tag, " div_out hi"}, 32'(hi), 32'(m_out(0)));
    check({tag, " tick"},       32'(tk), 32'(m_tick()));
    check({tag, " busy"},       32'(bz), 32'(m_busy()));
    check({tag, " cfg_err"},    32'(er), 32'(m_errv()));
    @(negedge clk);
    #2;
    lo = div_out;
    check({tag, " div_out lo"}, 32'(lo), 32'(m_out(1)));
  endtask

  task automatic do_reset(input string tag);
    en = '0; load = '0; sync = 1'b0; div_val = '0;
    rst = 1'b0;
    model_reset();
    #1;
    check({tag, " reset div_out"}, 32'(div_out), 32'(0));
    check({tag, " reset tick"},    32'(tick),    32'(0));
    check({tag, " reset busy"},    32'(busy),    32'(0));
    check({tag, " reset cfg_err"}, 32'(cfg_err), 32'(0));
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  typedef struct {
    bit               rst_first;
    logic [NCH-1:0]   en, load;
    logic [NCH*W-1:0] dv;
    logic             sync;
    logic [NCH-1:0]   hi, lo, tk, bz, er;
  } vec_t;

  vec_t tbl[12];
  logic [NCH-1:0] hi, lo, tk, bz, er;

  initial begin
    // Default D=3 on all channels; ch2 bad load mid-run; then ch0 loaded to D=4 while idle.
    tbl[0]  = '{1, 3'b111, 3'b000, 12'h000, 0, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000};
    tbl[1]  = '{0, 3'b111, 3'b000, 12'h000, 0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[2]  = '{0, 3'b111, 3'b000, 12'h000, 0, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000};
    tbl[3]  = '{0, 3'b111, 3'b000, 12'h000, 0, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000};
    tbl[4]  = '{0, 3'b111, 3'b100, 12'h100, 0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b100};
    tbl[5]  = '{0, 3'b111, 3'b000, 12'h000, 0, 3'b000, 3'b000, 3'b111, 3'b000, 3'b100};
    tbl[6]  = '{1, 3'b000, 3'b001, 12'h004, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[7]  = '{0, 3'b001, 3'b000, 12'h000, 0, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[8]  = '{0, 3'b001, 3'b000, 12'h000, 0, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[9]  = '{0, 3'b001, 3'b000, 12'h000, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[10] = '{0, 3'b001, 3'b000, 12'h000, 0, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
    tbl[11] = '{0, 3'b001, 3'b000, 12'h000, 0, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000};

    #2;
    for (int k = 0; k < 12; k++) begin
      if (tbl[k].rst_first) do_reset($sformatf("vec%0d", k));
      cycle(tbl[k].en, tbl[k].load, tbl[k].dv, tbl[k].sync, $sformatf("vec%0d", k), hi, lo, tk, bz, er);
      check($sformatf("vec%0d tbl hi", k),   32'(hi), 32'(tbl[k].hi));
      check($sformatf("vec%0d tbl lo", k),   32'(lo), 32'(tbl[k].lo));
      check($sformatf("vec%0d tbl tick", k), 32'(tk), 32'(tbl[k].tk));
      check($sformatf("vec%0d tbl busy", k), 32'(bz), 32'(tbl[k].bz));
      check($sformatf("vec%0d tbl err", k),  32'(er), 32'(tbl[k].er));
    end

    // ch1 at D=3 reloaded to D=7 mid-period: busy until wrap, then 7-cycle periods.
    do_reset("t3");
    cycle(3'b010, 3'b000, 12'h000, 0, "t3 start", hi, lo, tk, bz, er);
    cycle(3'b010, 3'b010, 12'h070, 0, "t3 load", hi, lo, tk, bz, er);
    check("t3 busy after load", 32'(bz[1]), 32'(1));
    cycle(3'b010, 3'b000, 12'h000, 0, "t3 pre-wrap", hi, lo, tk, bz, er);
    check("t3 busy before wrap", 32'(bz[1]), 32'(1));
    cycle(3'b010, 3'b000, 12'h000, 0, "t3 wrap", hi, lo, tk, bz, er);
    check("t3 busy after wrap", 32'(bz[1]), 32'(0));
    for (int k = 0; k < 14; k++) cycle(3'b010, 3'b000, 12'h000, 0, "t3 run", hi, lo, tk, bz, er);

    // ch0 D=5: drop en at cnt=1, drain to idle, then re-enable inside a drain.
    do_reset("t5");
    cycle(3'b000, 3'b001, 12'h005, 0, "t5 load", hi, lo, tk, bz, er);
    cycle(3'b001, 3'b000, 12'h000, 0, "t5 c0", hi, lo, tk, bz, er);
    cycle(3'b001, 3'b000, 12'h000, 0, "t5 c1", hi, lo, tk, bz, er);
    for (int k = 0; k < 4; k++) cycle(3'b000, 3'b000, 12'h000, 0, "t5 drain", hi, lo, tk, bz, er);
    check("t5 idle after drain", 32'(hi[0]), 32'(0));
    for (int k = 0; k < 3; k++) cycle(3'b001, 3'b000, 12'h000, 0, "t5 rerun", hi, lo, tk, bz, er);
    cycle(3'b000, 3'b000, 12'h000, 0, "t5 drop", hi, lo, tk, bz, er);
    for (int k = 0; k < 8; k++) cycle(3'b001, 3'b000, 12'h000, 0, "t5 resume", hi, lo, tk, bz, er);

    // ch0 D=4, ch1 D=6 started out of phase, aligned by sync; then reset mid-period.
    do_reset("t6");
    cycle(3'b000, 3'b011, 12'h064, 0, "t6 load", hi, lo, tk, bz, er);
    cycle(3'b001, 3'b000, 12'h000, 0, "t6 ch0", hi, lo, tk, bz, er);
    for (int k = 0; k < 3; k++) cycle(3'b011, 3'b000, 12'h000, 0, "t6 both", hi, lo, tk, bz, er);
    cycle(3'b011, 3'b000, 12'h000, 1, "t6 sync", hi, lo, tk, bz, er);
    check("t6 aligned rise", 32'(hi[1:0]), 32'(2'b11));
    cycle(3'b011, 3'b001, 12'h005, 0, "t6 pend", hi, lo, tk, bz, er);
    check("t6 pending before reset", 32'(bz[0]), 32'(1));
    #1;
    do_reset("t6 mid");

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic [NCH-1:0] e, l;
      for (int c = 0; c < NCH; c++) begin
        e[c] = $urandom_range(0, 9) < 8;
        l[c] = $urandom_range(0, 9) == 0;
      end
      cycle(e, l, (NCH*W)'($urandom), $urandom_range(0, 29) == 0, "rand", hi, lo, tk, bz, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
